// File: rtl/key_press_ctrl.sv
// Push-button debounce and short/long/auto-repeat press classifier; all event outputs are 1-cycle registered pulses.
// A level change commits DB_CYC+1 edges after key_in settles (2-flop sync + debounce); no backpressure, events are fire-and-forget.
module key_press_ctrl #(
  parameter int CLK_FREQ       = 50_000_000,
  parameter int DEBOUNCE_MS    = 20,
  parameter int LONG_MS        = 1000,
  parameter int REPEAT_MS      = 0,
  parameter bit KEY_ACTIVE_LOW = 1'b1
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key_in,
  output logic key_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic short_press,
  output logic long_press,
  output logic repeat_pulse
);

  localparam int DB_RAW     = CLK_FREQ / 1000 * DEBOUNCE_MS;
  localparam int LONG_RAW   = CLK_FREQ / 1000 * LONG_MS;
  localparam int REPEAT_RAW = CLK_FREQ / 1000 * REPEAT_MS;
  localparam int DB_CYC     = (DB_RAW < 1) ? 1 : DB_RAW;
  localparam int LONG_CYC   = (LONG_RAW < 1) ? 1 : LONG_RAW;
  localparam int REPEAT_CYC = (REPEAT_MS == 0) ? 0 : ((REPEAT_RAW < 1) ? 1 : REPEAT_RAW);
  localparam int MAX_A      = (DB_CYC > LONG_CYC) ? DB_CYC : LONG_CYC;
  localparam int MAX_CYC    = (MAX_A > REPEAT_CYC) ? MAX_A : REPEAT_CYC;
  localparam int CW         = $clog2(MAX_CYC) + 1;

  localparam logic [CW-1:0] DB_LAST   = CW'(DB_CYC - 1);
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYC - 1);
  localparam logic [CW-1:0] REP_LAST  = CW'((REPEAT_CYC == 0) ? 0 : REPEAT_CYC - 1);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_HELD = 2'b01;
  localparam logic [1:0] ST_LONG = 2'b10;

  logic          key_sense;
  logic          sync_0;
  logic          s;
  logic [CW-1:0] db_cnt;
  logic [CW-1:0] hold_cnt;
  logic [1:0]    state;
  logic          press_commit;
  logic          release_commit;

  assign key_sense = KEY_ACTIVE_LOW ? ~key_in : key_in;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      sync_0 <= 1'b0;
      s      <= 1'b0;
    end else begin
      sync_0 <= key_sense;
      s      <= sync_0;
    end
  end

  // Any disagreement shorter than DB_CYC cycles is discarded by clearing db_cnt.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      db_cnt    <= '0;
      key_level <= 1'b0;
    end else if (s == key_level) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      db_cnt    <= '0;
      key_level <= ~key_level;
    end else begin
      db_cnt <= db_cnt + CW'(1);
    end
  end

  assign press_commit   = s & ~key_level & (db_cnt == DB_LAST);
  assign release_commit = ~s & key_level & (db_cnt == DB_LAST);

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state         <= ST_IDLE;
      hold_cnt      <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      short_press   <= 1'b0;
      long_press    <= 1'b0;
      repeat_pulse  <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      short_press   <= 1'b0;
      long_press    <= 1'b0;
      repeat_pulse  <= 1'b0;
      case (state)
        ST_IDLE: begin
          hold_cnt <= '0;
          if (press_commit) begin
            press_pulse <= 1'b1;
            state       <= ST_HELD;
          end
        end
        // Release outranks the long threshold landing on the same edge.
        ST_HELD: begin
          if (release_commit) begin
            release_pulse <= 1'b1;
            short_press   <= 1'b1;
            hold_cnt      <= '0;
            state         <= ST_IDLE;
          end else if (hold_cnt == LONG_LAST) begin
            long_press <= 1'b1;
            hold_cnt   <= '0;
            state      <= ST_LONG;
          end else begin
            hold_cnt <= hold_cnt + CW'(1);
          end
        end
        ST_LONG: begin
          if (release_commit) begin
            release_pulse <= 1'b1;
            hold_cnt      <= '0;
            state         <= ST_IDLE;
          end else if (REPEAT_CYC > 0) begin
            if (hold_cnt == REP_LAST) begin
              repeat_pulse <= 1'b1;
              hold_cnt     <= '0;
            end else begin
              hold_cnt <= hold_cnt + CW'(1);
            end
          end else begin
            hold_cnt <= '0;
          end
        end
        default: begin
          state    <= ST_IDLE;
          hold_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_press_ctrl.sv
// Directed bench: two instances (repeat off / REPEAT_MS=5) driven by the same pin, every output checked on every edge.
module tb_key_press_ctrl;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;
  logic key_in    = 1'b1;

  logic kl0, pp0, rp0, sp0, lp0, rep0;
  logic kl1, pp1, rp1, sp1, lp1, rep1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 sys_clk = ~sys_clk;

  key_press_ctrl #(
    .CLK_FREQ(1000), .DEBOUNCE_MS(4), .LONG_MS(20), .REPEAT_MS(0), .KEY_ACTIVE_LOW(1'b1)
  ) u_dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .key_in(key_in),
    .key_level(kl0), .press_pulse(pp0), .release_pulse(rp0),
    .short_press(sp0), .long_press(lp0), .repeat_pulse(rep0)
  );

  key_press_ctrl #(
    .CLK_FREQ(1000), .DEBOUNCE_MS(4), .LONG_MS(20), .REPEAT_MS(5), .KEY_ACTIVE_LOW(1'b1)
  ) u_dut_rep (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .key_in(key_in),
    .key_level(kl1), .press_pulse(pp1), .release_pulse(rp1),
    .short_press(sp1), .long_press(lp1), .repeat_pulse(rep1)
  );

  // Expected {key_level, press, release, short, long, repeat} at edge e given hand-computed event edges.
  function automatic logic [5:0] exp_vec(int e, int p, int r, int l, bit sh, bit rep_en);
    logic kl, pr, rl, st, lg, rp;
    kl = (p >= 0) && (e >= p) && ((r < 0) || (e < r));
    pr = (e == p);
    rl = (e == r);
    st = (e == r) && sh;
    lg = (e == l);
    rp = rep_en && (l >= 0) && (e > l) && ((e - l) % 5 == 0) && ((r < 0) || (e < r));
    return {kl, pr, rl, st, lg, rp};
  endfunction

  function automatic logic key_at(int e, int press_len, bit bounce);
    if (bounce) return (e < 20) ? 1'((e / 2) % 2) : 1'b1;
    return (e < press_len) ? 1'b0 : 1'b1;
  endfunction

  task automatic check(input string tag, input int e, input logic [5:0] obs, input logic [5:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s edge %0d: got %b expected %b (kl,press,rel,short,long,rep)", tag, e, obs, exp);
    end
  endtask

  task automatic do_reset(input string tag);
    sys_rst_n = 1'b0;
    key_in    = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1;
    check({tag, "_rst"}, -1, {kl0, pp0, rp0, sp0, lp0, rep0}, 6'b0);
    check({tag, "_rst_rep"}, -1, {kl1, pp1, rp1, sp1, lp1, rep1}, 6'b0);
    sys_rst_n = 1'b1;
  endtask

  task automatic run_scn(input string tag, input int n, input int press_len, input bit bounce,
                         input int p, input int r, input int l, input bit sh);
    do_reset(tag);
    key_in = key_at(0, press_len, bounce);
    for (int e = 0; e < n; e++) begin
      @(posedge sys_clk);
      #1;
      check(tag, e, {kl0, pp0, rp0, sp0, lp0, rep0}, exp_vec(e, p, r, l, sh, 1'b0));
      check({tag, "_rep"}, e, {kl1, pp1, rp1, sp1, lp1, rep1}, exp_vec(e, p, r, l, sh, 1'b1));
      key_in = key_at(e + 1, press_len, bounce);
    end
  endtask

  task automatic run_reset_mid_hold();
    logic [5:0] exp;
    do_reset("rst_mid");
    key_in = 1'b0;
    for (int e = 0; e < 30; e++) begin
      @(posedge sys_clk);
      #1;
      if (e < 12)      exp = exp_vec(e, 5, -1, -1, 1'b0, 1'b0);
      else if (e < 14) exp = 6'b0;
      else             exp = exp_vec(e - 14, 5, -1, -1, 1'b0, 1'b0);
      check("rst_mid", e, {kl0, pp0, rp0, sp0, lp0, rep0}, exp);
      check("rst_mid_rep", e, {kl1, pp1, rp1, sp1, lp1, rep1}, exp);
      if (e == 11) sys_rst_n = 1'b0;
      if (e == 13) sys_rst_n = 1'b1;
    end
  endtask

  initial begin
    run_scn("clean_press",   15, 1000, 1'b0,  5, -1, -1, 1'b0);
    run_scn("bounce",        35,    0, 1'b1, -1, -1, -1, 1'b0);
    run_scn("short_press",   25,   10, 1'b0,  5, 15, -1, 1'b1);
    run_scn("long_press",    55,   40, 1'b0,  5, 45, 25, 1'b0);
    run_reset_mid_hold();
    run_scn("rel_at_thresh", 45,   20, 1'b0,  5, 25, -1, 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
